// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the next PC, runs the imem req/ack handshake
// and holds each fetched word for decode, applying jump/branch redirects on consumption.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] Instr_pc,
  output logic        Instr_valid,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [25:0] Jump_index,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic [31:0] Next_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        req_q;
  logic        valid_q;

  // Branch targets are word aligned; the low two bits are dropped.
  logic unused_btgt_lsbs;
  assign unused_btgt_lsbs = ^Branch_target[1:0];

  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_WAIT: begin
        if (Imem_ack) pc_d = pc_q + 32'(PC_STEP);
      end
      S_HOLD: begin
        if (!Stall) begin
          if (Jump)              pc_d = {pc_q[31:28], Jump_index, 2'b00};
          else if (Branch_taken) pc_d = {Branch_target[31:2], 2'b00};
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT;
          req_q   <= 1'b1;
        end
        S_WAIT: begin
          if (Imem_ack) begin
            state_q    <= S_HOLD;
            instr_q    <= Imem_rdata;
            instr_pc_q <= pc_q;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_req    = req_q;
  assign Imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign Instr_pc    = instr_pc_q;
  assign Instr_valid = valid_q;
  assign Next_pc     = pc_d;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of fetch/consume records plus hand-written
// reset, wrap-around and mid-fetch reset sequences; fetched words checked via a scoreboard.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Imem_ack = 1'b0;
  logic [31:0] Imem_rdata = 32'h0;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [25:0] Jump_index = 26'h0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_target = 32'h0;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_instr, a_instr_pc, a_next_pc;
  logic [31:0] b_addr, b_instr, b_instr_pc, b_next_pc;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Imem_req(a_req), .Imem_addr(a_addr),
    .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata), .Instr(a_instr),
    .Instr_pc(a_instr_pc), .Instr_valid(a_valid), .Stall(Stall), .Jump(Jump),
    .Jump_index(Jump_index), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .Next_pc(a_next_pc)
  );

  // Second instance sees identical stimulus; used for the wrap-around case.
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Imem_req(b_req), .Imem_addr(b_addr),
    .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata), .Instr(b_instr),
    .Instr_pc(b_instr_pc), .Instr_valid(b_valid), .Stall(Stall), .Jump(Jump),
    .Jump_index(Jump_index), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .Next_pc(b_next_pc)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;
  fetch_t sb_q[$];

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    int          stall_cyc;
    logic        jump;
    logic [25:0] jidx;
    logic        br;
    logic [31:0] btgt;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[6];
  vec_t plain;

  logic [31:0] exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Entered one tick after an edge with the DUT in WAIT at exp_addr.
  task automatic fetch(input int delay, input logic [31:0] rdata);
    fetch_t e;
    for (int i = 0; i < delay; i++) begin
      Jump = 1'b1; Jump_index = 26'h3FF_FFFF;
      Branch_taken = 1'b1; Branch_target = 32'hDEAD_BEEF;
      #1;
      chk("wait_req", a_req, 1);
      chk("wait_addr", a_addr, exp_addr);
      chk("wait_valid", a_valid, 0);
      chk("wait_next_pc", a_next_pc, exp_addr);
      step();
    end
    Imem_ack = 1'b1;
    Imem_rdata = rdata;
    #1;
    chk("ack_req", a_req, 1);
    chk("ack_addr", a_addr, exp_addr);
    chk("ack_next_pc", a_next_pc, exp_addr + 32'd4);
    e.instr = rdata;
    e.pc = exp_addr;
    sb_q.push_back(e);
    step();
    Imem_ack = 1'b0;
    Imem_rdata = $urandom;
    Jump = 1'b0;
    Branch_taken = 1'b0;
    chk("hold_valid", a_valid, 1);
    chk("hold_req", a_req, 0);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=valid required=expected_entry");
    end else begin
      e = sb_q.pop_front();
      chk("sb_instr", a_instr, e.instr);
      chk("sb_instr_pc", a_instr_pc, e.pc);
    end
    exp_addr = exp_addr + 32'd4;
    chk("hold_addr", a_addr, exp_addr);
  endtask

  // Entered one tick after the edge into HOLD.
  task automatic consume(input vec_t v);
    logic [31:0] held;
    held = a_instr;
    for (int i = 0; i < v.stall_cyc; i++) begin
      Stall = 1'b1;
      Branch_taken = (i == 1);
      Branch_target = 32'h0000_0080;
      Jump = (i == 2);
      Jump_index = 26'h000_1234;
      #1;
      chk("stall_valid", a_valid, 1);
      chk("stall_next_pc", a_next_pc, exp_addr);
      step();
      chk("stall_instr", a_instr, held);
    end
    Stall = 1'b0;
    Jump = v.jump;
    Jump_index = v.jidx;
    Branch_taken = v.br;
    Branch_target = v.btgt;
    #1;
    chk("consume_next_pc", a_next_pc, v.exp_next);
    step();
    Jump = 1'b0;
    Branch_taken = 1'b0;
    chk("consume_valid", a_valid, 0);
    chk("consume_req", a_req, 1);
    chk("redirect_addr", a_addr, v.exp_next);
    chk("kept_instr", a_instr, held);
    exp_addr = v.exp_next;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3, 32'h1111_1111, 4, 1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0008};
    vecs[1] = '{0, 32'h2222_2222, 0, 1'b0, 26'h0,        1'b1, 32'h0040_0013, 32'h0040_0010};
    vecs[2] = '{1, 32'h3333_3333, 0, 1'b1, 26'h010_0008, 1'b0, 32'h0,         32'h0040_0020};
    vecs[3] = '{0, 32'h4444_4444, 1, 1'b0, 26'h0,        1'b1, 32'h0000_0103, 32'h0000_0100};
    vecs[4] = '{2, 32'h5555_5555, 0, 1'b1, 26'h000_0080, 1'b1, 32'h0000_0300, 32'h0000_0200};
    vecs[5] = '{0, 32'h6666_6666, 2, 1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0204};

    #1 Rst_n = 1'b0;
    #2;
    chk("rst_req", a_req, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_instr_pc", a_instr_pc, 0);
    chk("rst_next_pc", a_next_pc, 32'h0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_next_pc_b", b_next_pc, 32'hFFFF_FFFC);

    #19 Rst_n = 1'b1;
    #1;
    chk("idle_req", a_req, 0);
    chk("idle_next_pc", a_next_pc, 32'h0);
    step();
    chk("first_req", a_req, 1);
    chk("first_addr", a_addr, 32'h0);
    exp_addr = 32'h0;
    fetch(0, 32'h2008_0005);
    chk("first_instr", a_instr, 32'h2008_0005);
    chk("first_next_pc", a_next_pc, 32'h4);
    chk("wrap_instr_pc_b", b_instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr_b", b_addr, 32'h0000_0000);
    chk("wrap_next_pc_b", b_next_pc, 32'h0000_0000);
    plain = '{0, 32'h0, 0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0004};
    consume(plain);
    chk("wrap_fetch_addr_b", b_addr, 32'h0000_0000);

    for (int r = 0; r < 6; r++) begin
      fetch(vecs[r].delay, vecs[r].rdata);
      consume(vecs[r]);
    end

    Imem_ack = 1'b1;
    Imem_rdata = 32'h7777_7777;
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_req", a_req, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_addr", a_addr, 32'h0);
    chk("midrst_next_pc", a_next_pc, 32'h0);
    step();
    chk("midrst_ack_dropped", a_valid, 0);
    Imem_ack = 1'b0;
    step();
    Rst_n = 1'b1;
    #1;
    chk("restart_idle_req", a_req, 0);
    step();
    chk("restart_req", a_req, 1);
    chk("restart_addr", a_addr, 32'h0);
    exp_addr = 32'h0;
    fetch(0, 32'h0BAD_CAFE);
    consume(plain);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
